axi4_bram_responder: RTL and testbench

- On-chip block-RAM AXI4 responder for the core's RAM port, which uses a single combined address channel (arw) carrying a write flag.
- Drop-in alternative to the DDR controller for boot RAM, scratchpad, and fast simulation without a DDR model.
- Echoes the transaction id on the B and R channels.
- Supports INCR bursts of 32-bit beats with byte strobes.

---
 rtl/axi4_bram_responder_if.sv | 54 +++++
 rtl/axi4_bram_responder.sv | 192 +++++++++++++++++++
 tb/tb_axi4_bram_responder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_bram_responder_if.sv
// Combined-address AXI4 bus between the core RAM port and a memory responder.
// One arw channel carries a write flag; W, B and R channels follow AXI4 naming.
interface axi4_bram_responder_if;
  logic        arw_valid;
  logic        arw_ready;
  logic [27:0] arw_addr;
  logic        arw_id;
  logic [7:0]  arw_len;
  logic [2:0]  arw_size;
  logic [1:0]  arw_burst;
  logic        arw_write;

  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;

  logic        b_valid;
  logic        b_ready;
  logic        b_id;

  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_id;
  logic        r_last;

  modport master (
    output arw_valid, arw_addr, arw_id,
    output arw_len, arw_size, arw_burst,
    output arw_write,
    input  arw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id,
    output b_ready,
    input  r_valid, r_data, r_id, r_last,
    output r_ready
  );

  modport slave (
    input  arw_valid, arw_addr, arw_id,
    input  arw_len, arw_size, arw_burst,
    input  arw_write,
    output arw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id,
    input  b_ready,
    output r_valid, r_data, r_id, r_last,
    input  r_ready
  );
endinterface

// File: rtl/axi4_bram_responder.sv
// Block-RAM AXI4 responder, INCR bursts of 32-bit beats, one transaction at a time.
// Define AXI4_BRAM_LAST_CHECK_EN to add a sticky protocol_error for bad w_last.
module axi4_bram_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input logic clk,
  input logic reset,
  axi4_bram_responder_if.slave bus
`ifdef AXI4_BRAM_LAST_CHECK_EN
  ,
  output logic protocol_error
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_WRESP = 2'd3;

  typedef logic [ADDR_WIDTH-1:0] waddr_t;

  logic [1:0] state_q, state_d;
  waddr_t     addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic       id_q, id_d;
  logic       r_valid_q, r_valid_d;
  logic       r_last_q, r_last_d;
  logic       b_valid_q, b_valid_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;
  logic        rd_en;
  waddr_t      rd_addr;
  logic        wr_en;

  logic   arw_hs, r_hs, w_hs;
  logic   last_beat;
  waddr_t arw_word;
  waddr_t addr_inc;

  assign bus.arw_ready = (state_q == S_IDLE);
  assign bus.w_ready   = (state_q == S_WRITE);
  assign bus.b_valid   = b_valid_q;
  assign bus.b_id      = id_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.r_last    = r_last_q;
  assign bus.r_id      = id_q;
  assign bus.r_data    = rd_q;

  assign arw_hs    = bus.arw_valid & bus.arw_ready;
  assign r_hs      = r_valid_q & bus.r_ready;
  assign w_hs      = bus.w_valid & bus.w_ready;
  assign last_beat = (cnt_q == len_q);
  assign arw_word  = bus.arw_addr[ADDR_WIDTH+1:2];
  assign addr_inc  = addr_q + waddr_t'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    b_valid_d = b_valid_q;
    rd_en     = 1'b0;
    rd_addr   = addr_inc;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arw_hs) begin
          id_d   = bus.arw_id;
          len_d  = bus.arw_len;
          cnt_d  = 8'd0;
          addr_d = arw_word;
          if (bus.arw_write) begin
            state_d = S_WRITE;
          end else begin
            state_d   = S_READ;
            rd_en     = 1'b1;
            rd_addr   = arw_word;
            r_valid_d = 1'b1;
            r_last_d  = (bus.arw_len == 8'd0);
          end
        end
      end
      S_READ: begin
        if (r_hs) begin
          if (r_last_q) begin
            state_d   = S_IDLE;
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
          end else begin
            rd_en    = 1'b1;
            addr_d   = addr_inc;
            cnt_d    = cnt_q + 8'd1;
            r_last_d = ((cnt_q + 8'd1) == len_q);
          end
        end
      end
      S_WRITE: begin
        if (w_hs) begin
          wr_en = 1'b1;
          if (last_beat) begin
            state_d   = S_WRESP;
            b_valid_d = 1'b1;
          end else begin
            addr_d = addr_inc;
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      S_WRESP: begin
        if (bus.b_ready) begin
          state_d   = S_IDLE;
          b_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      b_valid_q <= b_valid_d;
    end
  end

  // Memory has no reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.w_strb[i]) begin
          mem[addr_q][8*i +: 8] <= bus.w_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  logic unused_ok;

`ifdef AXI4_BRAM_LAST_CHECK_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (w_hs && (bus.w_last != last_beat)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign protocol_error = perr_q;
  assign unused_ok = ^{bus.arw_size, bus.arw_burst,
                       bus.arw_addr[27:ADDR_WIDTH+2],
                       bus.arw_addr[1:0]};
`else
  assign unused_ok = ^{bus.arw_size, bus.arw_burst,
                       bus.arw_addr[27:ADDR_WIDTH+2],
                       bus.arw_addr[1:0], bus.w_last};
`endif

endmodule

// File: tb/tb_axi4_bram_responder.sv
// Directed bench for axi4_bram_responder with a word-array memory model
// and expected-beat queues checked every cycle.
module tb_axi4_bram_responder;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  axi4_bram_responder_if bus();

`ifdef AXI4_BRAM_LAST_CHECK_EN
  logic protocol_error;
`endif

  axi4_bram_responder #(.ADDR_WIDTH(12)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus)
`ifdef AXI4_BRAM_LAST_CHECK_EN
    ,
    .protocol_error (protocol_error)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic        id;
    logic        last;
  } rbeat_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl [4096];
  rbeat_t      rq[$];
  logic        bq[$];
  logic [31:0] last_rdata;

  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Per-cycle comparison of R and B channels against expected queues.
  initial begin
    logic        pv;
    logic        pr;
    logic [31:0] pd;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pv = 1'b0;
        continue;
      end
      if (bus.r_valid) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL r_unexpected actual=valid required=idle");
        end else begin
          chk("r_data", bus.r_data, rq[0].d);
          chk("r_id", 32'(bus.r_id), 32'(rq[0].id));
          chk("r_last", 32'(bus.r_last), 32'(rq[0].last));
          if (bus.r_ready) begin
            last_rdata = bus.r_data;
            void'(rq.pop_front());
          end
        end
        if (pv && !pr) chk("r_stall_hold", bus.r_data, pd);
      end else if (pv && !pr) begin
        chk("r_valid_drop", 32'(bus.r_valid), 32'd1);
      end
      if (bus.b_valid) begin
        if (bq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected actual=valid required=idle");
        end else begin
          chk("b_id", 32'(bus.b_id), 32'(bq[0]));
          if (bus.b_ready) void'(bq.pop_front());
        end
      end
      pv = bus.r_valid;
      pr = bus.r_ready;
      pd = bus.r_data;
    end
  end

  task automatic arw_req(logic [27:0] a, logic id,
                         logic [7:0] len, logic wr);
    int n = 0;
    bus.arw_valid = 1'b1;
    bus.arw_addr  = a;
    bus.arw_id    = id;
    bus.arw_len   = len;
    bus.arw_size  = 3'b010;
    bus.arw_burst = 2'b01;
    bus.arw_write = wr;
    while (!bus.arw_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.arw_ready) fail_now("arw_wait");
    @(negedge clk);
    bus.arw_valid = 1'b0;
  endtask

  task automatic do_write(logic [27:0] a, logic id, logic [7:0] len);
    logic [11:0] w;
    int n;
    w = a[13:2];
    bq.push_back(id);
    bus.w_valid = 1'b1;
    bus.w_data  = wd[0];
    bus.w_strb  = ws[0];
    bus.w_last  = wl[0];
    chk("w_ready_idle", 32'(bus.w_ready), 32'd0);
    arw_req(a, id, len, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      logic [11:0] wi;
      bus.w_valid = 1'b1;
      bus.w_data  = wd[i];
      bus.w_strb  = ws[i];
      bus.w_last  = wl[i];
      n = 0;
      while (!bus.w_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.w_ready) begin
        fail_now("w_wait");
        break;
      end
      wi = w + 12'(i);
      for (int b = 0; b < 4; b++) begin
        if (ws[i][b]) mdl[wi][8*b +: 8] = wd[i][8*b +: 8];
      end
      @(negedge clk);
    end
    bus.w_valid = 1'b0;
    chk("b_valid_rise", 32'(bus.b_valid), 32'd1);
    bus.b_ready = 1'b1;
    @(negedge clk);
    bus.b_ready = 1'b0;
    chk("b_valid_clear", 32'(bus.b_valid), 32'd0);
  endtask

  task automatic do_read(logic [27:0] a, logic id, logic [7:0] len,
                         int mode, output int cyc);
    logic [11:0] w;
    w = a[13:2];
    for (int i = 0; i <= int'(len); i++) begin
      rq.push_back('{mdl[w + 12'(i)], id, (i == int'(len))});
    end
    bus.r_ready = (mode == 0);
    arw_req(a, id, len, 1'b0);
    chk("r_valid_latency", 32'(bus.r_valid), 32'd1);
    cyc = 0;
    while (rq.size() != 0 && cyc < 2000) begin
      if (mode == 1) bus.r_ready = (cyc % 2 == 0);
      @(negedge clk);
      cyc++;
    end
    if (rq.size() != 0) begin
      fail_now("r_drain");
      rq.delete();
    end
    bus.r_ready = 1'b0;
    chk("r_valid_after_last", 32'(bus.r_valid), 32'd0);
    chk("arw_ready_after_rd", 32'(bus.arw_ready), 32'd1);
  endtask

  task automatic fill(logic [7:0] len, logic [31:0] base,
                      logic [31:0] step);
    for (int i = 0; i < 256; i++) begin
      wd[i] = base + step * 32'(i);
      ws[i] = 4'hF;
      wl[i] = (i == int'(len));
    end
  endtask

  initial begin
    int cyc;
    reset         = 1'b1;
    bus.arw_valid = 1'b0;
    bus.arw_addr  = '0;
    bus.arw_id    = 1'b0;
    bus.arw_len   = '0;
    bus.arw_size  = 3'b010;
    bus.arw_burst = 2'b01;
    bus.arw_write = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.w_strb    = '0;
    bus.w_last    = 1'b0;
    bus.b_ready   = 1'b0;
    bus.r_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_arw_ready", 32'(bus.arw_ready), 32'd1);
    chk("rst_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_w_ready", 32'(bus.w_ready), 32'd0);
    chk("rst_r_last", 32'(bus.r_last), 32'd0);
    chk("rst_ids", {bus.r_id, bus.b_id}, 32'd0);
`ifdef AXI4_BRAM_LAST_CHECK_EN
    chk("rst_perr", 32'(protocol_error), 32'd0);
`endif

    fill(8'd0, 32'hDEADBEEF, 32'd0);
    do_write(28'h40, 1'b1, 8'd0);
    do_read(28'h40, 1'b0, 8'd0, 0, cyc);
    chk("single_rd", last_rdata, 32'hDEADBEEF);

    fill(8'd7, 32'd0, 32'd1);
    do_write(28'h100, 1'b0, 8'd7);
    do_read(28'h100, 1'b1, 8'd7, 1, cyc);
    chk("toggle_last", last_rdata, 32'd7);
    do_read(28'h100, 1'b0, 8'd7, 0, cyc);
    chk("throughput", 32'(cyc), 32'd8);

    fill(8'd0, 32'h11223344, 32'd0);
    do_write(28'h200, 1'b1, 8'd0);
    fill(8'd0, 32'hAABBCCDD, 32'd0);
    ws[0] = 4'b0101;
    do_write(28'h200, 1'b0, 8'd0);
    fill(8'd0, 32'hFFFFFFFF, 32'd0);
    ws[0] = 4'b0000;
    do_write(28'h200, 1'b1, 8'd0);
    do_read(28'h200, 1'b1, 8'd0, 0, cyc);
    chk("strobe_merge", last_rdata, 32'h11BB33DD);

    fill(8'd3, 32'hA0, 32'd1);
    do_write(28'h3FF8, 1'b1, 8'd3);
    do_read(28'h4000, 1'b0, 8'd0, 0, cyc);
    chk("alias_word0", last_rdata, 32'hA2);
    do_read(28'h3FF8, 1'b1, 8'd3, 1, cyc);
    chk("wrap_last", last_rdata, 32'hA3);

`ifdef AXI4_BRAM_LAST_CHECK_EN
    chk("perr_clean", 32'(protocol_error), 32'd0);
    fill(8'd3, 32'h500, 32'd1);
    wl[1] = 1'b1;
    wl[3] = 1'b0;
    do_write(28'h300, 1'b0, 8'd3);
    chk("perr_set", 32'(protocol_error), 32'd1);
    do_read(28'h300, 1'b1, 8'd3, 0, cyc);
    chk("perr_4beats", last_rdata, 32'h503);
    chk("perr_sticky", 32'(protocol_error), 32'd1);
`endif

    for (int i = 0; i < 8; i++) begin
      rq.push_back('{mdl[12'h040 + 12'(i)], 1'b0, (i == 7)});
    end
    bus.r_ready = 1'b1;
    arw_req(28'h100, 1'b0, 8'd7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rq.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.r_ready = 1'b0;
    chk("rr_r_valid", 32'(bus.r_valid), 32'd0);
    chk("rr_arw_ready", 32'(bus.arw_ready), 32'd1);
    chk("rr_r_last", 32'(bus.r_last), 32'd0);
    chk("rr_r_id", 32'(bus.r_id), 32'd0);
`ifdef AXI4_BRAM_LAST_CHECK_EN
    chk("rr_perr", 32'(protocol_error), 32'd0);
`endif
    do_read(28'h40, 1'b1, 8'd0, 0, cyc);
    chk("rr_data", last_rdata, 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
